dcache_responder: RTL and testbench

//   Data-side memory responder: the far end of the dmem_* request interface driven by the MEM stage.

---
 rtl/dcache_responder_if.sv | 43 ++++
 rtl/dcache_responder.sv | 125 ++++++++++++
 tb/tb_dcache_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dcache_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_responder_if
// Brief    : dmem_* request bus and pmem_* line burst bus of the data cache.
// Revision : 1.0 - initial release
// ============================================================================
interface dcache_responder_if #(
    parameter int S_OFFSET = 5
);
    localparam int LW = 8 * (2 ** S_OFFSET);

    logic [31:0]   dmem_addr;
    logic          dmem_read;
    logic          dmem_write;
    logic [3:0]    dmem_wmask;
    logic [31:0]   dmem_wdata;
    logic [31:0]   dmem_rdata;
    logic          dmem_resp;

    logic [31:0]   pmem_addr;
    logic          pmem_read;
    logic          pmem_write;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    // Cache side: serves dmem, masters pmem.
    modport slave (
        input  dmem_addr, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        input  pmem_rdata, pmem_resp,
        output dmem_rdata, dmem_resp,
        output pmem_addr, pmem_read, pmem_write, pmem_wdata
    );

    // Environment side: MEM stage requester plus next memory level.
    modport master (
        output dmem_addr, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        output pmem_rdata, pmem_resp,
        input  dmem_rdata, dmem_resp,
        input  pmem_addr, pmem_read, pmem_write, pmem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/dcache_responder.sv
`default_nettype none
// ============================================================================
// Module   : dcache_responder
// Brief    : Direct-mapped write-back line cache answering dmem word requests.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_responder #(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    dcache_responder_if.slave  bus
);
    localparam int LW    = 8 * (2 ** S_OFFSET);
    localparam int TW    = 32 - S_INDEX - S_OFFSET;
    localparam int SETS  = 2 ** S_INDEX;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FILL      = 2'd2
    } state_t;

    state_t              state_q;
    logic [SETS-1:0]     valid_q;
    logic [SETS-1:0]     dirty_q;
    logic [TW-1:0]       tag_q  [SETS];
    logic [LW-1:0]       data_q [SETS];

    logic [TW-1:0]       w_tag;
    logic [S_INDEX-1:0]  w_idx;
    logic [S_OFFSET-3:0] w_word;
    logic                w_req;
    logic                w_hit;
    logic [LW-1:0]       line_d;
    logic                w_unused_addr;

    assign w_tag         = bus.dmem_addr[31:S_INDEX+S_OFFSET];
    assign w_idx         = bus.dmem_addr[S_INDEX+S_OFFSET-1:S_OFFSET];
    assign w_word        = bus.dmem_addr[S_OFFSET-1:2];
    assign w_unused_addr = ^bus.dmem_addr[1:0];
    assign w_req         = bus.dmem_read | bus.dmem_write;
    assign w_hit         = valid_q[w_idx] && (tag_q[w_idx] == w_tag);

    // Byte-masked merge of the write data into the resident line.
    always_comb begin
        line_d = data_q[w_idx];
        for (int b = 0; b < 4; b++) begin
            if (bus.dmem_wmask[b]) begin
                line_d[32*w_word + 8*b +: 8] = bus.dmem_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        bus.dmem_resp  = 1'b0;
        bus.dmem_rdata = '0;
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        bus.pmem_addr  = '0;
        bus.pmem_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (rst_n && w_req && w_hit) begin
                    bus.dmem_resp  = 1'b1;
                    bus.dmem_rdata = data_q[w_idx][32*w_word +: 32];
                end
            end
            ST_WRITEBACK: begin
                bus.pmem_write = 1'b1;
                bus.pmem_addr  = {tag_q[w_idx], w_idx, {S_OFFSET{1'b0}}};
                bus.pmem_wdata = data_q[w_idx];
            end
            ST_FILL: begin
                bus.pmem_read  = 1'b1;
                bus.pmem_addr  = {w_tag, w_idx, {S_OFFSET{1'b0}}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            if (bus.dmem_write) begin
                                data_q[w_idx]  <= line_d;
                                dirty_q[w_idx] <= 1'b1;
                            end
                        end else if (valid_q[w_idx] && dirty_q[w_idx]) begin
                            state_q <= ST_WRITEBACK;
                        end else begin
                            state_q <= ST_FILL;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        dirty_q[w_idx] <= 1'b0;
                        state_q        <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // The request retries in IDLE and hits on the freshly filled line.
                    if (bus.pmem_resp) begin
                        data_q[w_idx]  <= bus.pmem_rdata;
                        tag_q[w_idx]   <= w_tag;
                        valid_q[w_idx] <= 1'b1;
                        dirty_q[w_idx] <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dcache_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_responder
// Brief    : Directed self-checking bench with a fixed-latency next-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_responder;
    logic clk;
    logic rst_n;
    logic l2_hold;

    int n_checks = 0;
    int n_errors = 0;
    int wb_cnt   = 0;
    int fill_cnt = 0;
    int lat      = 0;
    logic overlap = 1'b0;
    logic [31:0]  last_wb_addr   = '0;
    logic [31:0]  last_fill_addr = '0;
    logic [255:0] last_wb_line   = '0;
    logic [255:0] l2mem [256];

    dcache_responder_if #(.S_OFFSET(5)) ifc ();

    dcache_responder #(.S_INDEX(3), .S_OFFSET(5)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Next level: answers any pmem request on its third asserted cycle.
    initial begin : l2_model
        forever begin
            @(posedge clk);
            #1;
            ifc.pmem_resp = 1'b0;
            if (ifc.pmem_read && ifc.pmem_write) overlap = 1'b1;
            if (rst_n && !l2_hold && (ifc.pmem_read || ifc.pmem_write)) begin
                lat++;
                if (lat == 3) begin
                    if (ifc.pmem_write) begin
                        l2mem[ifc.pmem_addr[12:5]] = ifc.pmem_wdata;
                        last_wb_addr = ifc.pmem_addr;
                        last_wb_line = ifc.pmem_wdata;
                        wb_cnt++;
                    end else begin
                        ifc.pmem_rdata = l2mem[ifc.pmem_addr[12:5]];
                        last_fill_addr = ifc.pmem_addr;
                        fill_cnt++;
                    end
                    ifc.pmem_resp = 1'b1;
                    lat = 0;
                end
            end else begin
                lat = 0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the completing edge.
    task automatic do_req(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] wd, output logic [31:0] rdata,
                          output int cycles);
        logic seen;
        seen = 1'b0;
        rdata = '0;
        cycles = 0;
        ifc.dmem_addr  = addr;
        ifc.dmem_read  = rd;
        ifc.dmem_write = wr;
        ifc.dmem_wmask = mask;
        ifc.dmem_wdata = wd;
        while (!seen && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (ifc.dmem_resp) begin
                seen  = 1'b1;
                rdata = ifc.dmem_rdata;
            end
        end
        check_eq({tag, "_resp"}, {31'b0, seen}, 32'd1);
        @(posedge clk);
        #1;
        ifc.dmem_read  = 1'b0;
        ifc.dmem_write = 1'b0;
    endtask

    initial begin : stim
        logic [31:0] rd;
        int cyc;
        int f0;
        int w0;
        logic [31:0] exp_b2b [4];
        exp_b2b = '{32'hDEADBEEF, 32'h11225555, 32'hCAFEF00D, 32'h01234567};

        for (int l = 0; l < 256; l++)
            for (int w = 0; w < 8; w++)
                l2mem[l][32*w +: 32] = 32'hC0DE0000 | (l << 4) | w;
        l2mem[2][31:0]   = 32'hDEADBEEF;
        l2mem[2][63:32]  = 32'h11223344;
        l2mem[2][95:64]  = 32'hCAFEF00D;
        l2mem[2][127:96] = 32'h01234567;

        l2_hold = 1'b0;
        rst_n = 1'b0;
        ifc.dmem_addr = '0; ifc.dmem_read = 1'b0; ifc.dmem_write = 1'b0;
        ifc.dmem_wmask = '0; ifc.dmem_wdata = '0;
        ifc.pmem_rdata = '0; ifc.pmem_resp = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_dmem_resp", {31'b0, ifc.dmem_resp}, 32'd0);
        check_eq("rst_pmem_read", {31'b0, ifc.pmem_read}, 32'd0);
        check_eq("rst_pmem_write", {31'b0, ifc.pmem_write}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold read
        do_req("cold", 1, 0, 32'h40, 4'h0, 0, rd, cyc);
        check_eq("cold_rdata", rd, 32'hDEADBEEF);
        check_eq("cold_cycles", cyc, 5);
        check_eq("cold_fill_addr", last_fill_addr, 32'h40);
        check_eq("cold_wb_cnt", wb_cnt, 0);

        // Write hit then read back
        do_req("wr_hit", 0, 1, 32'h44, 4'b0011, 32'hAAAA5555, rd, cyc);
        check_eq("wr_hit_cycles", cyc, 1);
        f0 = fill_cnt;
        for (int i = 0; i < 4; i++) begin
            do_req("b2b", 1, 0, 32'h40 + 4*i, 4'h0, 0, rd, cyc);
            check_eq("b2b_rdata", rd, exp_b2b[i]);
            check_eq("b2b_cycles", cyc, 1);
        end
        check_eq("b2b_no_fill", fill_cnt, f0);

        // Dirty eviction
        do_req("dirty_ev", 1, 0, 32'h1040, 4'h0, 0, rd, cyc);
        check_eq("dirty_ev_rdata", rd, 32'hC0DE0820);
        check_eq("dirty_ev_cycles", cyc, 8);
        check_eq("dirty_ev_wb_cnt", wb_cnt, 1);
        check_eq("dirty_ev_wb_addr", last_wb_addr, 32'h40);
        check_eq("dirty_ev_wb_w0", last_wb_line[31:0], 32'hDEADBEEF);
        check_eq("dirty_ev_wb_w1", last_wb_line[63:32], 32'h11225555);
        check_eq("dirty_ev_fill_addr", last_fill_addr, 32'h1040);

        // Clean eviction, data comes back from the written-back line
        do_req("clean_ev", 1, 0, 32'h44, 4'h0, 0, rd, cyc);
        check_eq("clean_ev_rdata", rd, 32'h11225555);
        check_eq("clean_ev_cycles", cyc, 5);
        check_eq("clean_ev_wb_cnt", wb_cnt, 1);

        // Zero-mask write still dirties the line
        do_req("mask0", 0, 1, 32'h48, 4'b0000, 32'hFFFFFFFF, rd, cyc);
        check_eq("mask0_cycles", cyc, 1);
        do_req("mask0_rd", 1, 0, 32'h48, 4'h0, 0, rd, cyc);
        check_eq("mask0_rdata", rd, 32'hCAFEF00D);
        do_req("mask0_ev", 1, 0, 32'h1048, 4'h0, 0, rd, cyc);
        check_eq("mask0_ev_rdata", rd, 32'hC0DE0822);
        check_eq("mask0_ev_wb_cnt", wb_cnt, 2);
        check_eq("mask0_ev_cycles", cyc, 8);

        // Read and write together act as a write
        do_req("rdwr", 1, 1, 32'h1044, 4'b1111, 32'h5A5A5A5A, rd, cyc);
        do_req("rdwr_rd", 1, 0, 32'h1044, 4'h0, 0, rd, cyc);
        check_eq("rdwr_rdata", rd, 32'h5A5A5A5A);

        // Reset in the middle of a fill
        l2_hold = 1'b1;
        ifc.dmem_addr = 32'h60; ifc.dmem_read = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("midfill_pmem_read", {31'b0, ifc.pmem_read}, 32'd1);
        check_eq("midfill_pmem_addr", ifc.pmem_addr, 32'h60);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midfill_rst_pmem_read", {31'b0, ifc.pmem_read}, 32'd0);
        check_eq("midfill_rst_dmem_resp", {31'b0, ifc.dmem_resp}, 32'd0);
        ifc.dmem_read = 1'b0;
        rst_n = 1'b1;
        l2_hold = 1'b0;
        @(posedge clk);
        #1;
        f0 = fill_cnt;
        w0 = wb_cnt;
        do_req("post_rst", 1, 0, 32'h40, 4'h0, 0, rd, cyc);
        check_eq("post_rst_rdata", rd, 32'hDEADBEEF);
        check_eq("post_rst_fill", fill_cnt, f0 + 1);
        check_eq("post_rst_no_wb", wb_cnt, w0);
        check_eq("post_rst_cycles", cyc, 5);

        check_eq("no_overlap", {31'b0, overlap}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
